// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_SRC sources, bursts of up to MAX_BURST words.
// Latency: one cycle from the IDLE grant decision to the first write; one idle bubble between bursts.
// Backpressure: o_full stalls writes (src_ready low), o_alm_full blocks new grants and ends a burst.
module fifo_wr_arbiter #(
    parameter int N_SRC     = 4,
    parameter int DATA_W    = 128,
    parameter int MAX_BURST = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_SRC-1:0]          src_valid,
    input  logic [N_SRC*DATA_W-1:0]   src_data,
    output logic [N_SRC-1:0]          src_ready,
    input  logic                      o_full,
    input  logic                      o_alm_full,
    output logic                      i_wren,
    output logic [DATA_W-1:0]         i_wrdata,
    output logic [N_SRC-1:0]          gnt,
    output logic                      busy
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam int IDX_W = $clog2(N_SRC);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t             state, state_nxt;
    logic [N_SRC-1:0]   gnt_nxt;
    logic [IDX_W-1:0]   g_idx, g_nxt;
    logic [IDX_W-1:0]   rr_ptr, rr_nxt;
    logic [CNT_W-1:0]   beat_cnt, cnt_nxt;
    logic [IDX_W-1:0]   cand;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_vld;
    logic               write;
    logic [DATA_W-1:0]  src_word [N_SRC];

    for (genvar i = 0; i < N_SRC; i++) begin : g_unpack
        assign src_word[i] = src_data[i*DATA_W +: DATA_W];
    end

    // Walk candidates from the farthest back to rr_ptr so the nearest valid one wins.
    always_comb begin
        pick_vld = |src_valid;
        pick_idx = '0;
        cand     = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(rr_ptr) + k) % N_SRC);
            if (src_valid[cand]) begin
                pick_idx = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            gnt      <= '0;
            g_idx    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            g_idx    <= g_nxt;
            rr_ptr   <= rr_nxt;
            beat_cnt <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        g_nxt     = g_idx;
        rr_nxt    = rr_ptr;
        cnt_nxt   = beat_cnt;
        write     = 1'b0;
        case (state)
            IDLE: begin
                if (pick_vld && !o_alm_full && !o_full) begin
                    state_nxt = BURST;
                    g_nxt     = pick_idx;
                    gnt_nxt   = N_SRC'(1) << pick_idx;
                    cnt_nxt   = '0;
                end
            end
            BURST: begin
                write = src_valid[g_idx] && !o_full;
                // The word in an almost-full cycle still goes in; only the grant is released.
                if ((write && beat_cnt == CNT_W'(MAX_BURST - 1)) || !src_valid[g_idx] || o_alm_full) begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    cnt_nxt   = '0;
                    rr_nxt    = (g_idx == IDX_W'(N_SRC - 1)) ? '0 : g_idx + IDX_W'(1);
                end else begin
                    cnt_nxt = beat_cnt + CNT_W'(write);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        i_wren    = write;
        src_ready = gnt & {N_SRC{write}};
        i_wrdata  = write ? src_word[g_idx] : '0;
        busy      = (state == BURST);
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: cycle-by-cycle expected grant/write traces per scenario.
module tb_fifo_wr_arbiter;

    logic         clk;
    logic         reset;
    logic [3:0]   src_valid;
    logic [511:0] src_data;
    logic [3:0]   src_ready;
    logic         o_full;
    logic         o_alm_full;
    logic         i_wren;
    logic [127:0] i_wrdata;
    logic [3:0]   gnt;
    logic         busy;

    int total = 0;
    int bad   = 0;

    fifo_wr_arbiter #(.N_SRC(4), .DATA_W(128), .MAX_BURST(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .src_valid  (src_valid),
        .src_data   (src_data),
        .src_ready  (src_ready),
        .o_full     (o_full),
        .o_alm_full (o_alm_full),
        .i_wren     (i_wren),
        .i_wrdata   (i_wrdata),
        .gnt        (gnt),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] word(input int i);
        return {32'hC0DE_0000 + 32'(i), 32'h0000_1111 * 32'(i + 1),
                32'hF00D_0000 + 32'(i), 32'(i * 3 + 7)};
    endfunction

    for (genvar i = 0; i < 4; i++) begin : g_data
        assign src_data[i*128 +: 128] = word(i);
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // src < 0 means no grant expected this cycle.
    task automatic expect_cycle(input string tag, input int src, input bit wr);
        logic [3:0] eg;
        eg = (src < 0) ? 4'b0000 : 4'(1 << src);
        #1;
        chk({tag, ".gnt"},  gnt,  eg);
        chk({tag, ".busy"}, busy, (src >= 0));
        chk({tag, ".wren"}, i_wren, wr);
        chk({tag, ".rdy"},  src_ready, wr ? eg : 4'b0000);
        chk({tag, ".data"}, i_wrdata, (wr && src >= 0) ? word(src) : 128'h0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        src_valid  = 4'b0000;
        o_full     = 1'b0;
        o_alm_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        src_valid  = 4'b0000;
        o_full     = 1'b0;
        o_alm_full = 1'b0;

        // 1: single source, full burst, bubble, resume
        do_reset();
        expect_cycle("reset", -1, 1'b0);
        src_valid = 4'b0001;
        expect_cycle("t1.c0", -1, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            next_cycle();
            expect_cycle("t1.wr", 0, 1'b1);
        end
        next_cycle();
        expect_cycle("t1.bubble", -1, 1'b0);
        next_cycle();
        expect_cycle("t1.resume", 0, 1'b1);

        // 2: all sources, round robin 0,1,2,3,0 with wrap
        do_reset();
        src_valid = 4'b1111;
        expect_cycle("t2.c0", -1, 1'b0);
        for (int b = 0; b < 5; b++) begin
            for (int c = 0; c < 8; c++) begin
                next_cycle();
                expect_cycle($sformatf("t2.b%0d.wr", b), b % 4, 1'b1);
            end
            next_cycle();
            expect_cycle($sformatf("t2.b%0d.bub", b), -1, 1'b0);
        end

        // 3: o_full stall after 3rd word of source 1
        do_reset();
        src_valid = 4'b0010;
        expect_cycle("t3.c0", -1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            expect_cycle("t3.pre", 1, 1'b1);
        end
        for (int c = 0; c < 5; c++) begin
            next_cycle();
            o_full = 1'b1;
            expect_cycle("t3.stall", 1, 1'b0);
        end
        for (int c = 0; c < 5; c++) begin
            next_cycle();
            o_full = 1'b0;
            expect_cycle("t3.post", 1, 1'b1);
        end
        next_cycle();
        expect_cycle("t3.end", -1, 1'b0);

        // 4: source 2 drops valid after 3 words, then source 3 wins
        do_reset();
        src_valid = 4'b0100;
        expect_cycle("t4.c0", -1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            expect_cycle("t4.wr", 2, 1'b1);
        end
        next_cycle();
        src_valid = 4'b1001;
        expect_cycle("t4.drop", 2, 1'b0);
        next_cycle();
        expect_cycle("t4.idle", -1, 1'b0);
        next_cycle();
        expect_cycle("t4.src3", 3, 1'b1);

        // 5: almost-full blocks grant, then cuts a burst short
        do_reset();
        o_alm_full = 1'b1;
        src_valid  = 4'b0001;
        expect_cycle("t5.c0", -1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            expect_cycle("t5.blocked", -1, 1'b0);
        end
        next_cycle();
        o_alm_full = 1'b0;
        expect_cycle("t5.clear", -1, 1'b0);
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            expect_cycle("t5.wr", 0, 1'b1);
        end
        next_cycle();
        o_alm_full = 1'b1;
        expect_cycle("t5.lastwr", 0, 1'b1);
        next_cycle();
        expect_cycle("t5.idle", -1, 1'b0);
        next_cycle();
        expect_cycle("t5.hold", -1, 1'b0);

        // 6: reset mid-burst of source 2, then fresh arbitration from index 0
        do_reset();
        src_valid = 4'b0110;
        expect_cycle("t6.c0", -1, 1'b0);
        for (int c = 0; c < 8; c++) begin
            next_cycle();
            expect_cycle("t6.src1", 1, 1'b1);
        end
        next_cycle();
        expect_cycle("t6.bub", -1, 1'b0);
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            expect_cycle("t6.src2", 2, 1'b1);
        end
        reset = 1'b1;
        expect_cycle("t6.rst_now", -1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        expect_cycle("t6.rel", -1, 1'b0);
        next_cycle();
        expect_cycle("t6.first", 1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
